// File: rtl/stall_detect_unit.sv
// Branch/load-use hazard detector for the 5-stage MIPS-subset pipeline.
// Define STALL_COUNT_EN to add saturating stall-cycle counters for performance monitoring.
module stall_detect_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] EXop,
    input  logic [4:0] EXrd,
    input  logic [4:0] EXrs,
    input  logic [4:0] EXrt,
    input  logic [5:0] IDop,
    input  logic [4:0] IDrs,
    input  logic [4:0] IDrt,
    input  logic [5:0] MEMop,
    input  logic [4:0] MEMrt,
    output logic       IDstall,
    output logic       EXstall
`ifdef STALL_COUNT_EN
    ,
    output logic [CNT_W-1:0] id_stall_cnt,
    output logic [CNT_W-1:0] ex_stall_cnt
`endif
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;

    logic       ex_dst_vld;
    logic [4:0] ex_dst;
    logic       id_is_branch;
    logic       mem_load_vld;
    logic       ex_uses_rs;
    logic       ex_uses_rt;

    always_comb begin
        ex_dst_vld = 1'b0;
        ex_dst     = 5'd0;
        unique case (EXop)
            OpRtype: begin
                ex_dst_vld = 1'b1;
                ex_dst     = EXrd;
            end
            OpLw, OpAddi, OpSlti: begin
                ex_dst_vld = 1'b1;
                ex_dst     = EXrt;
            end
            default: ;
        endcase
    end

    always_comb begin
        id_is_branch = (IDop == OpBeq) || (IDop == OpBne);
        mem_load_vld = (MEMop == OpLw) && (MEMrt != 5'd0);
        ex_uses_rs   = (EXop == OpRtype) || (EXop == OpLw) || (EXop == OpSw) ||
                       (EXop == OpAddi) || (EXop == OpSlti);
        // SW store data in rt is forwarded late, so only R-type reads rt early enough to stall.
        ex_uses_rt   = (EXop == OpRtype);

        IDstall = id_is_branch &&
                  ((ex_dst_vld && (ex_dst != 5'd0) && ((ex_dst == IDrs) || (ex_dst == IDrt))) ||
                   (mem_load_vld && ((MEMrt == IDrs) || (MEMrt == IDrt))));

        EXstall = mem_load_vld &&
                  ((ex_uses_rs && (MEMrt == EXrs)) || (ex_uses_rt && (MEMrt == EXrt)));
    end

`ifdef STALL_COUNT_EN
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] id_cnt_q;
    logic [CNT_W-1:0] ex_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_cnt_q <= '0;
            ex_cnt_q <= '0;
        end else begin
            if (IDstall && (id_cnt_q != '1)) begin
                id_cnt_q <= id_cnt_q + CntOne;
            end
            if (EXstall && (ex_cnt_q != '1)) begin
                ex_cnt_q <= ex_cnt_q + CntOne;
            end
        end
    end

    assign id_stall_cnt = id_cnt_q;
    assign ex_stall_cnt = ex_cnt_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: tb/tb_stall_detect_unit.sv
// Scoreboard bench for stall_detect_unit: directed vectors queue their expected stall bits,
// a monitor pops and compares them on the falling edge.
module tb_stall_detect_unit;

    localparam int unsigned CNT_W = 16;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] BNE  = 6'b000101;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] SLTI = 6'b001010;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] EXop, IDop, MEMop;
    logic [4:0] EXrd, EXrs, EXrt, IDrs, IDrt, MEMrt;
    logic       IDstall, EXstall;
`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] id_stall_cnt, ex_stall_cnt;
`endif

    stall_detect_unit #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .EXop   (EXop),
        .EXrd   (EXrd),
        .EXrs   (EXrs),
        .EXrt   (EXrt),
        .IDop   (IDop),
        .IDrs   (IDrs),
        .IDrt   (IDrt),
        .MEMop  (MEMop),
        .MEMrt  (MEMrt),
        .IDstall(IDstall),
`ifdef STALL_COUNT_EN
        .EXstall(EXstall),
        .id_stall_cnt(id_stall_cnt),
        .ex_stall_cnt(ex_stall_cnt)
`else
        .EXstall(EXstall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int   id;
        logic exp_id;
        logic exp_ex;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so each queued vector is judged mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check($sformatf("v%0d IDstall", e.id), {31'd0, IDstall}, {31'd0, e.exp_id});
            check($sformatf("v%0d EXstall", e.id), {31'd0, EXstall}, {31'd0, e.exp_ex});
        end
    end

    task automatic baseline();
        EXop = RT; IDop = RT; MEMop = RT;
        EXrd = 5'd1; EXrs = 5'd2; EXrt = 5'd3;
        IDrs = 5'd4; IDrt = 5'd5; MEMrt = 5'd6;
    endtask

    // Inputs were set by the caller after a posedge; queue expectation and move to next cycle.
    task automatic issue(input int id, input logic eid, input logic eex);
        exp_t e;
        e.id = id; e.exp_id = eid; e.exp_ex = eex;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        baseline();
        @(posedge clk);
        #1;

        baseline(); issue(1, 1'b0, 1'b0);
        // EX producer -> branch in ID
        baseline(); IDop = BEQ; EXrd = 5'd21; IDrs = 5'd21; issue(2, 1'b1, 1'b0);
        baseline(); IDop = BNE; EXrd = 5'd21; IDrt = 5'd21; issue(3, 1'b1, 1'b0);
        baseline(); IDop = BEQ; EXop = LW;   EXrt = 5'd21; IDrs = 5'd21; issue(4, 1'b1, 1'b0);
        baseline(); IDop = BNE; EXop = ADDI; EXrt = 5'd21; IDrt = 5'd21; issue(5, 1'b1, 1'b0);
        baseline(); IDop = BEQ; EXop = SLTI; EXrt = 5'd21; IDrs = 5'd21; issue(6, 1'b1, 1'b0);
        baseline(); IDop = BEQ; EXop = SW;   EXrt = 5'd21; IDrs = 5'd21; issue(7, 1'b0, 1'b0);
        baseline(); IDop = BEQ; EXrd = 5'd0; IDrs = 5'd0; issue(8, 1'b0, 1'b0);
        baseline(); IDop = BEQ; EXop = JMP;  EXrt = 5'd21; IDrs = 5'd21; issue(9, 1'b0, 1'b0);
        baseline(); IDop = BEQ; EXop = RT;   EXrt = 5'd21; IDrs = 5'd21; issue(10, 1'b0, 1'b0);
        // MEM load -> branch in ID
        baseline(); IDop = BEQ; MEMop = LW; MEMrt = 5'd21; IDrs = 5'd21; issue(11, 1'b1, 1'b0);
        baseline(); IDop = BNE; MEMop = LW; MEMrt = 5'd21; IDrt = 5'd21; issue(12, 1'b1, 1'b0);
        baseline(); IDop = ADDI; MEMop = LW; MEMrt = 5'd21; IDrs = 5'd21; issue(13, 1'b0, 1'b0);
        baseline(); IDop = JMP; EXrd = 5'd21; IDrs = 5'd21; issue(14, 1'b0, 1'b0);
        baseline(); IDop = BEQ; MEMop = SW; MEMrt = 5'd21; IDrs = 5'd21; issue(15, 1'b0, 1'b0);
        // Load-use into EX
        baseline(); MEMop = LW; MEMrt = 5'd21; EXop = RT;   EXrs = 5'd21; issue(16, 1'b0, 1'b1);
        baseline(); MEMop = LW; MEMrt = 5'd21; EXop = LW;   EXrs = 5'd21; issue(17, 1'b0, 1'b1);
        baseline(); MEMop = LW; MEMrt = 5'd21; EXop = SW;   EXrs = 5'd21; issue(18, 1'b0, 1'b1);
        baseline(); MEMop = LW; MEMrt = 5'd21; EXop = ADDI; EXrs = 5'd21; issue(19, 1'b0, 1'b1);
        baseline(); MEMop = LW; MEMrt = 5'd21; EXop = SLTI; EXrs = 5'd21; issue(20, 1'b0, 1'b1);
        baseline(); MEMop = LW; MEMrt = 5'd21; EXop = RT;   EXrt = 5'd21; issue(21, 1'b0, 1'b1);
        baseline(); MEMop = LW; MEMrt = 5'd21; EXop = SW;   EXrt = 5'd21; issue(22, 1'b0, 1'b0);
        baseline(); MEMop = LW; MEMrt = 5'd21; EXop = LW;   EXrt = 5'd21; issue(23, 1'b0, 1'b0);
        baseline(); MEMop = LW; MEMrt = 5'd0;  EXrs = 5'd0; issue(24, 1'b0, 1'b0);
        baseline(); MEMop = LW; MEMrt = 5'd0;  IDop = BEQ; IDrs = 5'd0; EXrd = 5'd7;
        issue(25, 1'b0, 1'b0);
        baseline(); MEMop = SW; MEMrt = 5'd21; EXrs = 5'd21; issue(26, 1'b0, 1'b0);
        baseline(); MEMop = LW; MEMrt = 5'd21; EXop = JMP;  EXrs = 5'd21; issue(27, 1'b0, 1'b0);
        // Both stalls together, and rst must not mask them
        baseline(); IDop = BEQ; IDrs = 5'd21; MEMop = LW; MEMrt = 5'd21; EXrs = 5'd21;
        issue(28, 1'b1, 1'b1);
        rst = 1'b1; issue(29, 1'b1, 1'b1);
        rst = 1'b0;
        baseline(); issue(30, 1'b0, 1'b0);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end

`ifdef STALL_COUNT_EN
        // Async clear mid-cycle, then count five IDstall cycles, then clear again mid-count.
        baseline();
        #2 rst = 1'b1;
        #1;
        check("cnt clr id", 32'(id_stall_cnt), 32'd0);
        check("cnt clr ex", 32'(ex_stall_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        IDop = BEQ; EXrd = 5'd21; IDrs = 5'd21;
        repeat (5) @(posedge clk);
        #1;
        baseline();
        check("cnt id after 5", 32'(id_stall_cnt), 32'd5);
        check("cnt ex after 5", 32'(ex_stall_cnt), 32'd0);
        MEMop = LW; MEMrt = 5'd21; EXrs = 5'd21;
        repeat (3) @(posedge clk);
        #1;
        check("cnt ex after 3", 32'(ex_stall_cnt), 32'd3);
        check("cnt id held", 32'(id_stall_cnt), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("cnt rst id", 32'(id_stall_cnt), 32'd0);
        check("cnt rst ex", 32'(ex_stall_cnt), 32'd0);
        rst = 1'b0;
        baseline();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

endmodule
